// File: rtl/tone_mapper.sv
// tone_mapper: packs serial bits into 1/2/4-bit carrier words, 1 cycle from last bit to do_vld; optional pilots (TMU_PILOT_EN).
// Output register holds while do_vld && !do_rdy; di_rdy is low then and while a pilot is being inserted.
`timescale 1ns/1ps

module tone_mapper #(
   parameter int                 MAX_BPC       = 4,
   parameter int                 NUM_CARRIER   = 96,
   parameter int                 PILOT_SPACING = 8,
   parameter logic [MAX_BPC-1:0] PILOT_VAL     = MAX_BPC'(1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [1:0]                     mode,
   input  logic                           di,
   input  logic                           di_vld,
   output logic                           di_rdy,
   // "do" is a reserved word, so the carrier value port is do_dat
   output logic [MAX_BPC-1:0]             do_dat,
   output logic                           do_vld,
   input  logic                           do_rdy,
   output logic                           do_sym_end,
   output logic [$clog2(NUM_CARRIER)-1:0] do_idx
);

   localparam int IW = $clog2(NUM_CARRIER);
   localparam int CW = $clog2(MAX_BPC + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CARRIER - 1);

`ifdef TMU_PILOT_EN
   typedef enum logic {COLLECT, PILOT} state_t;
`else
   typedef enum logic {COLLECT} state_t;
`endif

   state_t             state, state_nx;
   logic [1:0]         mode_lat;
   logic               sym_first;
   logic [IW-1:0]      cur_idx;
   logic [CW-1:0]      cnt;
   logic [MAX_BPC-1:0] sh;
   logic               can_load, take, last_bit, pilot_load;
   logic [1:0]         eff_mode;
   logic [CW-1:0]      bpc;
   logic [MAX_BPC-1:0] word;

   assign can_load = !do_vld || do_rdy;
   // the first data bit of a symbol uses the live mode, which is latched on that same edge
   assign eff_mode = sym_first ? mode : mode_lat;
   assign take     = di_vld && di_rdy;
   assign word     = sh | (MAX_BPC'(di) << cnt);
   assign last_bit = take && ((cnt + CW'(1)) == bpc);

   always_comb begin
      bpc = CW'(2);
      case (eff_mode)
         2'b00:   bpc = CW'(1);
         2'b10:   bpc = CW'(4);
         default: bpc = CW'(2);
      endcase
   end

   always_comb begin
      state_nx   = state;
      di_rdy     = 1'b0;
      pilot_load = 1'b0;
`ifdef TMU_PILOT_EN
      case (state)
         COLLECT: begin
            if (cnt == '0 && (int'(cur_idx) % PILOT_SPACING) == 0) state_nx = PILOT;
            else                                                    di_rdy   = can_load;
         end
         PILOT: begin
            if (can_load) begin
               pilot_load = 1'b1;
               state_nx   = COLLECT;
            end
         end
         default: state_nx = COLLECT;
      endcase
`else
      di_rdy = can_load;
`endif
   end

`ifndef TMU_PILOT_EN
   logic unused_cfg;
   assign unused_cfg = (^PILOT_VAL) ^ (PILOT_SPACING == 0);
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= COLLECT;
         mode_lat   <= 2'b00;
         sym_first  <= 1'b1;
         cur_idx    <= '0;
         cnt        <= '0;
         sh         <= '0;
         do_dat     <= '0;
         do_vld     <= 1'b0;
         do_sym_end <= 1'b0;
         do_idx     <= '0;
      end else begin
         state <= state_nx;
         if (take) begin
            sym_first <= 1'b0;
            if (sym_first) mode_lat <= mode;
         end
         if (last_bit || pilot_load) begin
            do_dat     <= pilot_load ? PILOT_VAL : word;
            do_vld     <= 1'b1;
            do_idx     <= cur_idx;
            do_sym_end <= (cur_idx == LAST_IDX);
            cnt        <= '0;
            sh         <= '0;
            if (cur_idx == LAST_IDX) begin
               cur_idx   <= '0;
               sym_first <= 1'b1;
            end else begin
               cur_idx <= cur_idx + IW'(1);
            end
         end else begin
            if (take) begin
               sh  <= word;
               cnt <= cnt + CW'(1);
            end
            if (do_rdy) do_vld <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tone_mapper.sv
// Bench for tone_mapper: directed scenarios plus randomized traffic against a queue-based carrier model.
`timescale 1ns/1ps

module tb_tone_mapper;

   localparam int N  = 8;
   localparam int PS = 4;

   logic       clk = 1'b0, rst = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       di = 1'b0, di_vld = 1'b0, do_rdy = 1'b1;
   logic       di_rdy, do_vld, do_sym_end;
   logic [3:0] do_dat;
   logic [2:0] do_idx;
   logic       s_di_rdy, s_do_vld, s_do_sym_end;
   logic [3:0] s_do_dat;
   logic [1:0] s_do_idx;

   int checks = 0, errors = 0;

   tone_mapper #(.MAX_BPC(4), .NUM_CARRIER(N), .PILOT_SPACING(PS), .PILOT_VAL(4'h1)) dut (
      .clk(clk), .rst(rst), .mode(mode), .di(di), .di_vld(di_vld), .di_rdy(di_rdy),
      .do_dat(do_dat), .do_vld(do_vld), .do_rdy(do_rdy), .do_sym_end(do_sym_end), .do_idx(do_idx));

   tone_mapper #(.MAX_BPC(4), .NUM_CARRIER(4), .PILOT_SPACING(4), .PILOT_VAL(4'h1)) dut_n4 (
      .clk(clk), .rst(rst), .mode(mode), .di(di), .di_vld(di_vld), .di_rdy(s_di_rdy),
      .do_dat(s_do_dat), .do_vld(s_do_vld), .do_rdy(do_rdy), .do_sym_end(s_do_sym_end), .do_idx(s_do_idx));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // reference model: carriers built from the accepted bit stream
   typedef struct { int dat; int idx; int last; } exp_t;
   exp_t eq[$];
   exp_t mon_e;
   int   m_bits[$];
   int   m_idx = 0, m_bpc = 1;
   bit   m_new = 1'b1;

   function automatic int bpc_of(input logic [1:0] m);
      case (m)
         2'b00:   return 1;
         2'b10:   return 4;
         default: return 2;
      endcase
   endfunction

   task automatic m_emit(input int val);
      exp_t e;
      e.dat  = val;
      e.idx  = m_idx;
      e.last = (m_idx == N - 1) ? 1 : 0;
      eq.push_back(e);
      m_idx = (m_idx + 1) % N;
      if (m_idx == 0) m_new = 1'b1;
   endtask

   task automatic m_pilots();
`ifdef TMU_PILOT_EN
      while (m_idx % PS == 0) m_emit(1);
`endif
   endtask

   task automatic m_reset();
      eq.delete();
      m_bits.delete();
      m_idx = 0;
      m_new = 1'b1;
      m_bpc = 1;
      m_pilots();
   endtask

   task automatic m_bit(input logic b, input logic [1:0] md);
      int v = 0;
      if (m_new) begin
         m_bpc = bpc_of(md);
         m_new = 1'b0;
      end
      m_bits.push_back(int'(b));
      if (m_bits.size() == m_bpc) begin
         foreach (m_bits[i]) v += m_bits[i] << i;
         m_bits.delete();
         m_emit(v);
         m_pilots();
      end
   endtask

   logic       st_f = 1'b0, st_end;
   logic [3:0] st_dat;
   logic [2:0] st_idx;

   always @(negedge clk) begin
      if (!rst) begin
         m_reset();
         st_f = 1'b0;
      end else begin
         if (st_f) begin
            chk("hold_vld", do_vld, 1);
            chk("hold_dat", do_dat, st_dat);
            chk("hold_idx", do_idx, st_idx);
            chk("hold_end", do_sym_end, st_end);
         end
         if (do_vld && do_rdy) begin
            chk("out_pending", eq.size() > 0, 1);
            if (eq.size() > 0) begin
               mon_e = eq.pop_front();
               chk("out_dat", do_dat, mon_e.dat);
               chk("out_idx", do_idx, mon_e.idx);
               chk("out_end", do_sym_end, mon_e.last);
            end
         end
         if (di_vld && di_rdy) m_bit(di, mode);
         st_f   = do_vld && !do_rdy;
         st_dat = do_dat;
         st_idx = do_idx;
         st_end = do_sym_end;
      end
   end

   task automatic do_reset();
      rst    = 1'b0;
      di_vld = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic send_bit(input logic b);
      bit acc = 1'b0;
      di     = b;
      di_vld = 1'b1;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         acc = di_rdy;
         @(posedge clk); #1;
      end
      chk("accept", acc, 1);
   endtask

   int         t28_bits[8] = '{1, 0, 0, 1, 1, 1, 0, 0};
   int         t28_exp[4]  = '{1, 2, 3, 0};
   logic [3:0] w1, w2, w3, w4;
   logic [7:0] b30;
   int         acc32;
   bit         seen32;

   initial begin
      @(posedge clk); #1;
      do_reset();
      chk("rst_vld", do_vld, 0);
      chk("rst_dat", do_dat, 0);
      chk("rst_idx", do_idx, 0);
      chk("rst_end", do_sym_end, 0);
`ifdef TMU_PILOT_EN
      chk("rst_rdy", di_rdy, 0);
`else
      chk("rst_rdy", di_rdy, 1);

      // four QPSK carriers on a four-carrier symbol
      mode   = 2'b01;
      do_rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send_bit(t28_bits[i][0]);
         if (i % 2 == 0) begin
            chk("n4_gap_vld", s_do_vld, 0);
         end else begin
            chk("n4_vld", s_do_vld, 1);
            chk("n4_dat", s_do_dat, t28_exp[i/2]);
            chk("n4_idx", s_do_idx, i / 2);
            chk("n4_end", s_do_sym_end, (i == 7) ? 1 : 0);
         end
      end
      di_vld = 1'b0;

      // 16QAM with a five-cycle downstream stall
      do_reset();
      mode = 2'b10;
      w1   = 4'($urandom);
      w2   = 4'($urandom);
      for (int i = 0; i < 4; i++) send_bit(w1[i]);
      chk("qam_lat_vld", do_vld, 1);
      chk("qam_dat", do_dat, w1);
      do_rdy = 1'b0;
      di     = w2[0];
      di_vld = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("stall_rdy", di_rdy, 0);
         chk("stall_vld", do_vld, 1);
         chk("stall_dat", do_dat, w1);
      end
      @(posedge clk); #1;
      do_rdy = 1'b1;
      for (int i = 0; i < 4; i++) send_bit(w2[i]);
      chk("qam2_dat", do_dat, w2);
      chk("qam2_idx", do_idx, 1);
      di_vld = 1'b0;

      // mode change mid-symbol takes effect at the next symbol
      do_reset();
      mode = 2'b00;
      b30  = 8'($urandom);
      send_bit(b30[0]);
      send_bit(b30[1]);
      mode = 2'b10;
      for (int i = 2; i < 8; i++) begin
         send_bit(b30[i]);
         chk("bpsk_vld", do_vld, 1);
         chk("bpsk_dat", do_dat, {3'b000, b30[i]});
         chk("bpsk_idx", do_idx, i);
      end
      chk("bpsk_end", do_sym_end, 1);
      w3 = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
         send_bit(w3[i]);
         if (i < 3) chk("nxt_wait", do_vld, 0);
      end
      chk("nxt_dat", do_dat, w3);
      chk("nxt_idx", do_idx, 0);
      di_vld = 1'b0;

      // reset in the middle of carrier 5
      do_reset();
      mode = 2'b10;
      for (int i = 0; i < 23; i++) send_bit(1'($urandom));
      chk("pre_rst_idx", do_idx, 4);
      do_reset();
      chk("mid_rst_vld", do_vld, 0);
      chk("mid_rst_dat", do_dat, 0);
      chk("mid_rst_idx", do_idx, 0);
      chk("mid_rst_end", do_sym_end, 0);
      chk("mid_rst_rdy", di_rdy, 1);
      w4 = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
         send_bit(w4[i]);
         if (i < 3) chk("fresh_wait", do_vld, 0);
      end
      chk("fresh_dat", do_dat, w4);
      chk("fresh_idx", do_idx, 0);
      di_vld = 1'b0;
`endif

`ifdef TMU_PILOT_EN
      // pilots at carriers 0 and 4, BPSK data elsewhere
      do_reset();
      mode   = 2'b00;
      do_rdy = 1'b1;
      di     = 1'($urandom);
      di_vld = 1'b1;
      acc32  = 0;
      seen32 = 1'b0;
      for (int k = 0; k < 60 && !seen32; k++) begin
         @(negedge clk);
         if (di_rdy) acc32++;
         if (do_vld) begin
            if (do_idx == 3'd0 || do_idx == 3'd4) chk("pil_val", do_dat, 1);
            if (do_idx[1:0] == 2'd3) chk("pil_rdy", di_rdy, 0);
            if (do_idx == 3'd7) seen32 = 1'b1;
         end
         @(posedge clk); #1;
         di = 1'($urandom);
      end
      chk("pil_seen", seen32, 1);
      chk("pil_bits", acc32, 6);
      di_vld = 1'b0;
`endif

      // randomized traffic, mode changes and occasional resets
      for (int k = 0; k < 3000; k++) begin
         di     = 1'($urandom);
         di_vld = ($urandom_range(0, 9) < 7);
         do_rdy = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
         rst = ($urandom_range(0, 399) != 0);
         @(posedge clk); #1;
      end
      rst    = 1'b1;
      di_vld = 1'b0;
      do_rdy = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("drain", eq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
